// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W    : bits added per clock
//   state_t     : controller state encoding (11 is unreachable, treated as IDLE)
//   calc_steps  : number of nibble steps for a given operand width
//   calc_step_w : step counter width, never less than one bit
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   function automatic int calc_steps(input int width);
      return width / NIBBLE_W;
   endfunction

   function automatic int calc_step_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
//   master : operand source and result consumer side
//   slave  : adder side
//   in_valid/in_ready   operand handshake, a/b/cin operands
//   out_valid/out_ready result handshake, sum/cout result
interface nibble_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/nibble_serial_adder_nibble.sv
// Nibble-wide ripple adder with live carry-in, plus its full-adder cell.
//   full_adder       : a, b, ci -> s, co
//   nibble_adder_cin : a[3:0], b[3:0], ci -> s[3:0], co (four cells, LSB to MSB)
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_adder_cin
   import nibble_serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co
);
   logic [NIBBLE_W:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign co = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder, one nibble per clock through a single
// registered-carry ripple stage.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of nibble_serial_adder_if (operand and result handshakes)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for operands; capture a/b/cin on in_valid
// RUN   | add one nibble per edge, shift result in from the MSB end
// DONE  | result held on sum/cout until out_ready
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   nibble_serial_adder_if.slave bus
);
   localparam int N      = calc_steps(WIDTH);
   localparam int STEP_W = calc_step_w(N);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

   state_t                    state;
   state_t                    state_nxt;
   logic                      is_idle;
   logic                      running;
   logic                      accept;

   logic [WIDTH-1:0]          op_a;
   logic [WIDTH-1:0]          op_b;
   logic                      carry;
   logic [STEP_W-1:0]         step;
   logic [WIDTH-1:0]          sum_r;
   logic                      cout_r;

   logic [NIBBLE_W-1:0]       nib_s;
   logic                      nib_co;
   logic [WIDTH+NIBBLE_W-1:0] sum_cat;

   nibble_adder_cin u_nib (
      .a  (op_a[NIBBLE_W-1:0]),
      .b  (op_b[NIBBLE_W-1:0]),
      .ci (carry),
      .s  (nib_s),
      .co (nib_co)
   );

   // New nibble enters at the top; after N steps the LSB nibble sits at [3:0].
   assign sum_cat = {nib_s, sum_r};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_RUN:  state_nxt = (step == LAST_STEP) ? ST_DONE : ST_RUN;
         ST_DONE: state_nxt = bus.out_ready ? ST_IDLE : ST_DONE;
         default: state_nxt = bus.in_valid ? ST_RUN : ST_IDLE;
      endcase
   end

   // The unused 11 encoding behaves as IDLE.
   always_comb begin
      is_idle       = (state != ST_RUN) && (state != ST_DONE);
      running       = (state == ST_RUN);
      accept        = is_idle && bus.in_valid;
      bus.in_ready  = is_idle && !rst;
      bus.out_valid = (state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         carry  <= 1'b0;
         step   <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
      end else if (accept) begin
         op_a  <= bus.a;
         op_b  <= bus.b;
         carry <= bus.cin;
         step  <= '0;
      end else if (running) begin
         op_a  <= op_a >> NIBBLE_W;
         op_b  <= op_b >> NIBBLE_W;
         sum_r <= sum_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
         carry <= nib_co;
         step  <= step + STEP_W'(1);
         if (step == LAST_STEP) begin
            cout_r <= nib_co;
         end
      end
   end

   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   nibble_serial_adder_if #(.WIDTH(16)) if16 ();
   nibble_serial_adder_if #(.WIDTH(4))  if4 ();

   nibble_serial_adder #(.WIDTH(16)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (if16)
   );

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (if4)
   );

   // One 16-bit operation with out_ready high: latency, result, 1-cycle pulse.
   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin, input string name);
      logic [16:0] exp;
      int cnt;
      exp = {1'b0, a} + {1'b0, b} + 17'(cin);
      cnt = 0;
      while (!if16.in_ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      n_checks++;
      if (if16.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s in_ready: got %b want 1", name, if16.in_ready);
      end
      if16.a = a; if16.b = b; if16.cin = cin;
      if16.out_ready = 1'b1;
      if16.in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if16.in_valid = 1'b0;
      cnt = 1;
      while (!if16.out_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      n_checks++;
      if (cnt !== 5) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want 5", name, cnt);
      end
      n_checks++;
      if ({if16.cout, if16.sum} !== exp) begin
         n_fail++;
         $display("FAIL %s result: got %h want %h", name, {if16.cout, if16.sum}, exp);
      end
      @(negedge clk);
      n_checks++;
      if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s after-done: got out_valid=%b in_ready=%b want 0 1",
                  name, if16.out_valid, if16.in_ready);
      end
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin);
      logic [4:0] exp;
      int cnt;
      exp = {1'b0, a} + {1'b0, b} + 5'(cin);
      cnt = 0;
      while (!if4.in_ready && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      if4.a = a; if4.b = b; if4.cin = cin;
      if4.out_ready = 1'b1;
      if4.in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if4.in_valid = 1'b0;
      cnt = 1;
      while (!if4.out_valid && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      n_checks++;
      if (cnt !== 2) begin
         n_fail++;
         $display("FAIL w4 latency a=%h b=%h cin=%b: got %0d want 2", a, b, cin, cnt);
      end
      n_checks++;
      if ({if4.cout, if4.sum} !== exp) begin
         n_fail++;
         $display("FAIL w4 result a=%h b=%h cin=%b: got %h want %h", a, b, cin, {if4.cout, if4.sum}, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (if16.in_ready !== 1'b0 || if16.out_valid !== 1'b0 || if16.sum !== 16'h0 || if16.cout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset16: got rdy=%b vld=%b sum=%h cout=%b want 0 0 0000 0",
                  if16.in_ready, if16.out_valid, if16.sum, if16.cout);
      end
      n_checks++;
      if (if4.in_ready !== 1'b0 || if4.out_valid !== 1'b0 || if4.sum !== 4'h0 || if4.cout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset4: got rdy=%b vld=%b sum=%h cout=%b want 0 0 0 0",
                  if4.in_ready, if4.out_valid, if4.sum, if4.cout);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (if16.in_ready !== 1'b1 || if4.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset release in_ready: got %b %b want 1 1", if16.in_ready, if4.in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_directed();
      op16(16'h1234, 16'h4321, 1'b0, "basic");
      op16(16'hFFFF, 16'h0001, 1'b0, "ripple_all");
      op16(16'hFFFF, 16'h0000, 1'b1, "cin_ripple");
      op16(16'h8000, 16'h8000, 1'b0, "msb_carry");
      op16(16'hFFFF, 16'hFFFF, 1'b1, "max");
   endtask

   task automatic test_random16();
      for (int i = 0; i < 20; i++) begin
         op16(16'($urandom), 16'($urandom), 1'($urandom), "random16");
      end
   endtask

   task automatic test_backpressure();
      logic [16:0] exp;
      int cnt;
      exp = 17'h0_100E;
      if16.a = 16'h00FF; if16.b = 16'h0F0F; if16.cin = 1'b0;
      if16.out_ready = 1'b0;
      if16.in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if16.in_valid = 1'b0;
      cnt = 1;
      while (!if16.out_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      n_checks++;
      if (cnt !== 5) begin
         n_fail++;
         $display("FAIL bp latency: got %0d want 5", cnt);
      end
      for (int i = 0; i < 7; i++) begin
         n_checks++;
         if (if16.out_valid !== 1'b1 || if16.in_ready !== 1'b0 || {if16.cout, if16.sum} !== exp) begin
            n_fail++;
            $display("FAIL bp hold cycle %0d: got vld=%b rdy=%b res=%h want 1 0 %h",
                     i, if16.out_valid, if16.in_ready, {if16.cout, if16.sum}, exp);
         end
         if (i == 2) begin
            if16.a = 16'hAAAA; if16.b = 16'h5555; if16.in_valid = 1'b1;
         end else begin
            if16.in_valid = 1'b0;
         end
         if (i == 6) if16.out_ready = 1'b1;
         if (i < 6) @(negedge clk);
      end
      @(negedge clk);
      n_checks++;
      if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp release: got vld=%b rdy=%b want 0 1", if16.out_valid, if16.in_ready);
      end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         n_checks++;
         if (if16.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp ignored pulse: got out_valid=%b want 0 at cycle %0d", if16.out_valid, i);
         end
      end
      op16(16'h1111, 16'h2222, 1'b0, "after_bp");
   endtask

   task automatic test_reset_mid_run();
      if16.a = 16'h1234; if16.b = 16'h1111; if16.cin = 1'b1;
      if16.out_ready = 1'b1;
      if16.in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if16.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b0 || if16.sum !== 16'h0 || if16.cout !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun reset: got vld=%b rdy=%b sum=%h cout=%b want 0 0 0000 0",
                  if16.out_valid, if16.in_ready, if16.sum, if16.cout);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (if16.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrun in_ready after release: got %b want 1", if16.in_ready);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (if16.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun aborted result: got out_valid=%b want 0 at cycle %0d", if16.out_valid, i);
         end
      end
      op16(16'h0001, 16'h0001, 1'b0, "after_reset");
   endtask

   // in_valid held high, out_ready high: a new op every N+2 = 6 cycles.
   task automatic test_back_to_back();
      logic [16:0] q[$];
      logic [16:0] exp;
      int last;
      int ops;
      int cnt;
      last = -1;
      ops  = 0;
      if16.out_ready = 1'b1;
      if16.a = 16'($urandom); if16.b = 16'($urandom); if16.cin = 1'($urandom);
      if16.in_valid = 1'b1;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (if16.out_valid) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b unexpected result: got %h want none", {if16.cout, if16.sum});
            end else begin
               exp = q.pop_front();
               if ({if16.cout, if16.sum} !== exp) begin
                  n_fail++;
                  $display("FAIL b2b result: got %h want %h", {if16.cout, if16.sum}, exp);
               end
            end
            if (last >= 0) begin
               n_checks++;
               if (cyc - last !== 6) begin
                  n_fail++;
                  $display("FAIL b2b period: got %0d want 6", cyc - last);
               end
            end
            last = cyc;
            ops++;
         end
         if (if16.in_ready) begin
            q.push_back({1'b0, if16.a} + {1'b0, if16.b} + 17'(if16.cin));
         end else begin
            if16.a = 16'($urandom); if16.b = 16'($urandom); if16.cin = 1'($urandom);
         end
         @(negedge clk);
      end
      if16.in_valid = 1'b0;
      cnt = 0;
      while (q.size() != 0 && cnt < 30) begin
         if (if16.out_valid) begin
            exp = q.pop_front();
            n_checks++;
            if ({if16.cout, if16.sum} !== exp) begin
               n_fail++;
               $display("FAIL b2b drain result: got %h want %h", {if16.cout, if16.sum}, exp);
            end
         end
         @(negedge clk);
         cnt++;
      end
      n_checks++;
      if (q.size() != 0 || ops < 10) begin
         n_fail++;
         $display("FAIL b2b completion: got pending=%0d ops=%0d want 0 >=10", q.size(), ops);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_sweep4();
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               op4(4'(a), 4'(b), 1'(c));
            end
         end
      end
   endtask

   initial begin
      if16.in_valid = 1'b0; if16.out_ready = 1'b1;
      if16.a = '0; if16.b = '0; if16.cin = 1'b0;
      if4.in_valid = 1'b0; if4.out_ready = 1'b1;
      if4.a = '0; if4.b = '0; if4.cin = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_random16();
      test_back_to_back();
      test_sweep4();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential multi-word adder that adds two WIDTH-bit operands four bits per clock through a single registered-carry 4-bit ripple stage. It trades latency for area in datapaths wider than one nibble, and reuses the existing full-adder/half-adder gate primitives. It sits between an operand source and a result consumer, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for the whole addition.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered sum, a+b+cin mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

## Operation
- N = WIDTH/4 nibble steps. Internal state: op_a, op_b shift registers, carry register, step counter, and the sum shift register.
- State machine has three states:
  - IDLE: in_ready=1. When in_valid=1, the edge captures a, b and cin, clears step to 0, and moves to RUN.
  - RUN: each edge adds nibble [3:0] of op_a and op_b to the carry register. The 4-bit result shifts into sum from the MSB end, and op_a/op_b shift right by 4. The carry register takes the nibble carry-out and step increments. On the edge where step==N-1, the state moves to DONE and cout takes the final carry.
  - DONE: out_valid=1. sum and cout hold stable. When out_ready=1, the edge moves the state to IDLE.
- in_ready = (state==IDLE) && !rst. in_ready is never high in RUN or DONE; in_valid in those states is ignored and is not queued.
- out_valid = (state==DONE).
- Result is exact: {cout,sum} = a + b + cin, a (WIDTH+1)-bit value.
- There is no overflow or signed interpretation; signed overflow is the consumer's job.
- Reset:
  - During reset, state goes to IDLE and sum, cout, carry and step go to 0. in_ready=0 and out_valid=0.
  - Reset asserted in RUN or DONE aborts the operation with no result emitted.
  - The first in_ready=1 is in the cycle after rst deasserts.
- Simultaneous events:
  - rst has priority over every handshake.
  - In DONE with out_ready=1 and in_valid=1, only the output completes. The new operand is accepted on the following IDLE cycle, never on the same edge.

## Timing
- Acceptance edge is T, where in_valid && in_ready.
- RUN occupies edges T+1 … T+N. out_valid is high from the cycle after edge T+N, so latency from acceptance to out_valid is N+1 cycles. For WIDTH=16, out_valid is first high 5 cycles after the acceptance cycle.
- Throughput with out_ready tied high is one operation per N+2 cycles.
- The nibble stage is a purely combinational 4-bit ripple path, one nibble per cycle. The carry register breaks the chain, so the critical path is 4 full-adder delays plus register setup, independent of WIDTH.
- All outputs except in_ready are registered. in_ready is decoded from the registered state plus rst.

## Structure
- Shared package holds:
  - NIBBLE_W = 4.
  - State enum IDLE/RUN/DONE, 2-bit encoding 00/01/10; 11 is unreachable and decodes to IDLE.
  - A function computing N from WIDTH.
- Sub-module nibble_adder_cin: 4-bit ripple adder with carry-in and carry-out, built from four full-adder instances chained LSB to MSB.
  - Instantiated once.
  - Kept distinct from the fixed cin=0 four-bit adder already in the library, because this block needs a live carry-in.
- Step counter width is clog2(N), minimum 1. WIDTH=4 (N=1) must be supported: RUN lasts exactly one edge.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 → sum=0x5555, cout=0; out_valid high exactly 5 cycles after acceptance for 1 cycle; in_ready back to 1 the next cycle.
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1; the carry propagates through all 4 nibble steps.
- WIDTH=16, a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1. Then a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1.
- Backpressure: a=0x00FF, b=0x0F0F, out_ready=0 for 6 cycles after out_valid rises → sum=0x100E, cout=0, both stable throughout. in_ready stays 0 and a pulse on in_valid during this window is ignored. After out_ready=1, the next op proceeds normally.
- Reset mid-RUN: assert rst for 1 cycle at step 2 → next cycle state=IDLE, sum=0, cout=0, out_valid=0, no result emitted. The following op 0x0001+0x0001 gives 0x0002.
- WIDTH=4, exhaustive sweep of all 512 (a,b,cin) combinations with out_ready=1 → every {cout,sum} equals a+b+cin; out_valid latency is always 2 cycles.
